// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard.
// Combinational reads with optional same-cycle write bypass and optional hardwired x0.
module regfile_mp #(
   parameter int unsigned XLEN     = 32'd32,
   parameter int unsigned NUM_REGS = 32'd32,
   parameter int unsigned NUM_RD   = 32'd2,
   parameter int unsigned NUM_WR   = 32'd1,
   parameter int unsigned BYPASS   = 32'd1,
   parameter int unsigned ZERO_REG = 32'd1,
   localparam int unsigned IDX     = $clog2(NUM_REGS)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NUM_RD*IDX-1:0]    rs_s_i,
   output logic [NUM_RD*XLEN-1:0]   rs_v_o,
   output logic [NUM_RD-1:0]        rs_busy_o,
   input  logic [NUM_WR-1:0]        we_i,
   input  logic [NUM_WR*IDX-1:0]    rd_s_i,
   input  logic [NUM_WR*XLEN-1:0]   rd_v_i,
   input  logic [NUM_WR-1:0]        rel_i,
   input  logic                     alloc_i,
   input  logic [IDX-1:0]           alloc_s_i
);

   localparam logic BYP_EN  = (BYPASS != 32'd0);
   localparam logic ZERO_EN = (ZERO_REG != 32'd0);

   logic [XLEN-1:0]     regs_r    [NUM_REGS];
   logic [NUM_REGS-1:0] busy_r;

   logic [XLEN-1:0]     wr_data_s [NUM_REGS];
   logic [NUM_REGS-1:0] wr_hit_s;
   logic [NUM_REGS-1:0] set_s;
   logic [NUM_REGS-1:0] clr_s;
   logic [NUM_REGS-1:0] keep_s;
   logic [NUM_REGS-1:0] busy_nxt_s;

   // Resolve writes, releases and allocs per register; later write ports override earlier ones
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         keep_s[r]    = !(ZERO_EN && (IDX'(r) == {IDX{1'b0}}));
         wr_hit_s[r]  = 1'b0;
         clr_s[r]     = 1'b0;
         wr_data_s[r] = regs_r[r];
         for (int w = 0; w < NUM_WR; w++) begin
            wr_hit_s[r]  = wr_hit_s[r] | (we_i[w] & (rd_s_i[w*IDX +: IDX] == IDX'(r)));
            clr_s[r]     = clr_s[r] | (we_i[w] & rel_i[w] & (rd_s_i[w*IDX +: IDX] == IDX'(r)));
            wr_data_s[r] = (we_i[w] && (rd_s_i[w*IDX +: IDX] == IDX'(r)) && keep_s[r])
                           ? rd_v_i[w*XLEN +: XLEN] : wr_data_s[r];
         end
         wr_hit_s[r] = wr_hit_s[r] & keep_s[r];
         clr_s[r]    = clr_s[r] & keep_s[r];
         set_s[r]    = alloc_i & (alloc_s_i == IDX'(r)) & keep_s[r];
      end
      busy_nxt_s = set_s | (busy_r & ~clr_s);
   end

   // Register array and scoreboard state
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_r[r] <= {XLEN{1'b0}};
         end
         busy_r <= {NUM_REGS{1'b0}};
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_r[r] <= wr_data_s[r];
         end
         busy_r <= busy_nxt_s;
      end
   end

   // Read ports: bypass uses the resolved write data, so the winning port is shared with the array update
   always_comb begin
      rs_v_o    = {(NUM_RD*XLEN){1'b0}};
      rs_busy_o = {NUM_RD{1'b0}};
      for (int p = 0; p < NUM_RD; p++) begin
         if (ZERO_EN && (rs_s_i[p*IDX +: IDX] == {IDX{1'b0}})) begin
            rs_v_o[p*XLEN +: XLEN] = {XLEN{1'b0}};
            rs_busy_o[p]           = 1'b0;
         end else if (BYP_EN) begin
            rs_v_o[p*XLEN +: XLEN] = wr_data_s[rs_s_i[p*IDX +: IDX]];
            rs_busy_o[p]           = busy_r[rs_s_i[p*IDX +: IDX]]
                                     & ~(clr_s[rs_s_i[p*IDX +: IDX]] & ~set_s[rs_s_i[p*IDX +: IDX]]);
         end else begin
            rs_v_o[p*XLEN +: XLEN] = regs_r[rs_s_i[p*IDX +: IDX]];
            rs_busy_o[p]           = busy_r[rs_s_i[p*IDX +: IDX]];
         end
      end
   end

   logic unused_s;
   assign unused_s = ^wr_hit_s;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: two instances (bypass+zero-reg dual-write, and no-bypass/no-zero)
// with expectations queued at drive time and popped at the sample point.
module tb_regfile_mp;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // instance A: NUM_WR=2, BYPASS=1, ZERO_REG=1
   logic [9:0]  a_rs;
   logic [63:0] a_rs_v;
   logic [1:0]  a_busy;
   logic [1:0]  a_we;
   logic [9:0]  a_rd;
   logic [63:0] a_rv;
   logic [1:0]  a_rel;
   logic        a_alloc;
   logic [4:0]  a_alloc_s;

   // instance B: NUM_WR=1, BYPASS=0, ZERO_REG=0
   logic [9:0]  b_rs;
   logic [63:0] b_rs_v;
   logic [1:0]  b_busy;
   logic [0:0]  b_we;
   logic [4:0]  b_rd;
   logic [31:0] b_rv;
   logic [0:0]  b_rel;
   logic        b_alloc;
   logic [4:0]  b_alloc_s;

   regfile_mp #(.NUM_WR(2), .BYPASS(1), .ZERO_REG(1)) u_a (
      .clk_i(clk), .rst_i(rst), .rs_s_i(a_rs), .rs_v_o(a_rs_v), .rs_busy_o(a_busy),
      .we_i(a_we), .rd_s_i(a_rd), .rd_v_i(a_rv), .rel_i(a_rel),
      .alloc_i(a_alloc), .alloc_s_i(a_alloc_s)
   );

   regfile_mp #(.NUM_WR(1), .BYPASS(0), .ZERO_REG(0)) u_b (
      .clk_i(clk), .rst_i(rst), .rs_s_i(b_rs), .rs_v_o(b_rs_v), .rs_busy_o(b_busy),
      .we_i(b_we), .rd_s_i(b_rd), .rd_v_i(b_rv), .rel_i(b_rel),
      .alloc_i(b_alloc), .alloc_s_i(b_alloc_s)
   );

   typedef struct {
      int          sel;
      logic [31:0] exp;
      string       tag;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   localparam int A_V0 = 0, A_V1 = 1, A_B0 = 2, A_B1 = 3;
   localparam int B_V0 = 4, B_V1 = 5, B_B0 = 6, B_B1 = 7;

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         A_V0:    return a_rs_v[31:0];
         A_V1:    return a_rs_v[63:32];
         A_B0:    return {31'd0, a_busy[0]};
         A_B1:    return {31'd0, a_busy[1]};
         B_V0:    return b_rs_v[31:0];
         B_V1:    return b_rs_v[63:32];
         B_B0:    return {31'd0, b_busy[0]};
         B_B1:    return {31'd0, b_busy[1]};
         default: return 32'hxxxxxxxx;
      endcase
   endfunction

   task automatic expect_v(input int sel, input logic [31:0] v, input string tag);
      exp_t e;
      e.sel = sel;
      e.exp = v;
      e.tag = tag;
      sb_q.push_back(e);
   endtask

   task automatic check_now();
      exp_t        e;
      logic [31:0] obs;
      #1;
      while (sb_q.size() > 0) begin
         e   = sb_q.pop_front();
         obs = observe(e.sel);
         checks++;
         assert (obs === e.exp)
         else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      a_we = 2'b00; a_rd = 10'd0; a_rv = 64'd0; a_rel = 2'b00; a_alloc = 1'b0; a_alloc_s = 5'd0;
      b_we = 1'b0;  b_rd = 5'd0;  b_rv = 32'd0; b_rel = 1'b0;  b_alloc = 1'b0; b_alloc_s = 5'd0;
   endtask

   task automatic a_read(input logic [4:0] p0, input logic [4:0] p1);
      a_rs = {p1, p0};
   endtask

   task automatic b_read(input logic [4:0] p0, input logic [4:0] p1);
      b_rs = {p1, p0};
   endtask

   initial begin
      idle();
      a_read(5'd0, 5'd0);
      b_read(5'd0, 5'd0);

      // 1: reset, then every index on every port reads 0 / not busy
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 32; i++) begin
         a_read(5'(i), 5'(31 - i));
         b_read(5'(31 - i), 5'(i));
         expect_v(A_V0, 32'd0, "rst_a_v0");
         expect_v(A_V1, 32'd0, "rst_a_v1");
         expect_v(A_B0, 32'd0, "rst_a_b0");
         expect_v(A_B1, 32'd0, "rst_a_b1");
         expect_v(B_V0, 32'd0, "rst_b_v0");
         expect_v(B_V1, 32'd0, "rst_b_v1");
         expect_v(B_B0, 32'd0, "rst_b_b0");
         expect_v(B_B1, 32'd0, "rst_b_b1");
         check_now();
      end

      // 2: write x5, same-cycle read differs by bypass setting
      b_we = 1'b1; b_rd = 5'd5; b_rv = 32'hDEADBEEF; b_read(5'd0, 5'd5);
      a_we = 2'b01; a_rd = {5'd0, 5'd5}; a_rv = {32'd0, 32'hDEADBEEF}; a_read(5'd0, 5'd5);
      expect_v(B_V1, 32'd0, "wr_nobyp_same");
      expect_v(A_V1, 32'hDEADBEEF, "wr_byp_same");
      expect_v(A_V0, 32'd0, "wr_byp_other");
      check_now();
      tick();
      idle();
      expect_v(B_V1, 32'hDEADBEEF, "wr_nobyp_next");
      expect_v(A_V1, 32'hDEADBEEF, "wr_byp_next");
      check_now();

      // 3: zero register
      a_we = 2'b01; a_rd = {5'd0, 5'd0}; a_rv = {32'd0, 32'h00001234}; a_alloc = 1'b1; a_alloc_s = 5'd0;
      a_read(5'd0, 5'd0);
      b_we = 1'b1; b_rd = 5'd0; b_rv = 32'h00001234; b_alloc = 1'b1; b_alloc_s = 5'd0;
      b_read(5'd0, 5'd0);
      expect_v(A_V0, 32'd0, "zr_byp_v");
      expect_v(A_B0, 32'd0, "zr_byp_busy");
      expect_v(B_V0, 32'd0, "nozr_same_v");
      check_now();
      tick();
      idle();
      expect_v(A_V0, 32'd0, "zr_next_v");
      expect_v(A_B1, 32'd0, "zr_next_busy");
      expect_v(B_V0, 32'h00001234, "nozr_next_v0");
      expect_v(B_V1, 32'h00001234, "nozr_next_v1");
      expect_v(B_B0, 32'd1, "nozr_next_busy");
      check_now();

      // 4: write conflict on x7, then two distinct writes
      a_we = 2'b11; a_rd = {5'd7, 5'd7}; a_rv = {32'h5555FFFF, 32'hAAAA0000};
      a_read(5'd7, 5'd7);
      expect_v(A_V0, 32'h5555FFFF, "conf_byp_v0");
      expect_v(A_V1, 32'h5555FFFF, "conf_byp_v1");
      check_now();
      tick();
      idle();
      expect_v(A_V0, 32'h5555FFFF, "conf_next_v0");
      check_now();
      a_we = 2'b11; a_rd = {5'd11, 5'd10}; a_rv = {32'h22222222, 32'h11111111};
      a_read(5'd10, 5'd11);
      expect_v(A_V0, 32'h11111111, "dual_byp_v0");
      expect_v(A_V1, 32'h22222222, "dual_byp_v1");
      check_now();
      tick();
      idle();
      a_read(5'd11, 5'd10);
      expect_v(A_V0, 32'h22222222, "dual_next_v0");
      expect_v(A_V1, 32'h11111111, "dual_next_v1");
      check_now();

      // 5: scoreboard
      a_alloc = 1'b1; a_alloc_s = 5'd3; a_read(5'd3, 5'd3);
      b_alloc = 1'b1; b_alloc_s = 5'd3; b_read(5'd3, 5'd3);
      expect_v(A_B0, 32'd0, "alloc_same");
      check_now();
      tick();
      idle();
      expect_v(A_B0, 32'd1, "alloc_next_b0");
      expect_v(A_B1, 32'd1, "alloc_next_b1");
      expect_v(B_B0, 32'd1, "b_alloc_next");
      check_now();
      a_we = 2'b10; a_rd = {5'd3, 5'd0}; a_rv = {32'h00000033, 32'd0}; a_rel = 2'b10;
      b_we = 1'b1; b_rd = 5'd3; b_rv = 32'h00000033; b_rel = 1'b1;
      expect_v(A_B0, 32'd0, "rel_byp_same");
      expect_v(A_V0, 32'h00000033, "rel_byp_v");
      expect_v(B_B0, 32'd1, "rel_nobyp_same");
      check_now();
      tick();
      idle();
      expect_v(A_B0, 32'd0, "rel_next");
      expect_v(B_B0, 32'd0, "b_rel_next");
      check_now();
      a_alloc = 1'b1; a_alloc_s = 5'd4; a_read(5'd4, 5'd3);
      tick();
      idle();
      a_rel = 2'b01; a_rd = {5'd0, 5'd4};
      expect_v(A_B0, 32'd1, "rel_no_we_same");
      check_now();
      tick();
      idle();
      expect_v(A_B0, 32'd1, "rel_no_we_next");
      check_now();
      a_alloc = 1'b1; a_alloc_s = 5'd3;
      a_we = 2'b01; a_rd = {5'd0, 5'd3}; a_rv = {32'd0, 32'h00000077}; a_rel = 2'b01;
      expect_v(A_B1, 32'd0, "set_clr_same");
      expect_v(A_V1, 32'h00000077, "set_clr_v");
      check_now();
      tick();
      idle();
      expect_v(A_B1, 32'd1, "set_clr_next");
      check_now();

      // 6: reset mid-operation
      a_alloc = 1'b1; a_alloc_s = 5'd9; a_read(5'd9, 5'd5);
      tick();
      idle();
      a_we = 2'b01; a_rd = {5'd0, 5'd9}; a_rv = {32'd0, 32'h00000042};
      tick();
      idle();
      expect_v(A_V0, 32'h00000042, "pre_rst_v");
      expect_v(A_B0, 32'd1, "pre_rst_busy");
      check_now();
      rst = 1'b1;
      a_we = 2'b01; a_rd = {5'd0, 5'd9}; a_rv = {32'd0, 32'h00000099};
      a_alloc = 1'b1; a_alloc_s = 5'd9;
      b_we = 1'b1; b_rd = 5'd5; b_rv = 32'h00000099; b_alloc = 1'b1; b_alloc_s = 5'd5;
      tick();
      rst = 1'b0;
      idle();
      b_read(5'd5, 5'd0);
      expect_v(A_V0, 32'd0, "post_rst_v9");
      expect_v(A_B0, 32'd0, "post_rst_b9");
      expect_v(A_V1, 32'd0, "post_rst_v5");
      expect_v(B_V0, 32'd0, "post_rst_b_v5");
      expect_v(B_V1, 32'd0, "post_rst_b_v0");
      expect_v(B_B0, 32'd0, "post_rst_b_busy5");
      expect_v(B_B1, 32'd0, "post_rst_b_busy0");
      check_now();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
